// File: rtl/ysyx_23060208_wb_sched.sv
// ysyx_23060208_wb_sched
// Writeback scheduler with a register scoreboard.
//   - Issue reserves a destination register (alloc_*); the busy bit stays set
//     until a writeback to that register is accepted.
//   - Two writeback sources (s0 = EXU, s1 = LSU) share one regfile write port
//     through a 1-bit round-robin arbiter; the winner is registered and drives
//     rf_wen/rf_waddr/rf_wdata one cycle after its handshake.
//   - chk_addr1/chk_addr2 query hazards, including the write still sitting in
//     the output register.
//   - flush drops every reservation; err is a sticky flag for a writeback to a
//     register that was never reserved.
// Ports: clock, reset (async active-low), alloc_*, s0_*, s1_*, rf_*, chk_*,
//        flush, idle, err.
module ysyx_23060208_wb_sched #(
   parameter int REG_WIDTH  = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alloc_valid,
   input  logic [REG_WIDTH-1:0]  alloc_addr,
   output logic                  alloc_ready,
   input  logic                  s0_valid,
   input  logic [REG_WIDTH-1:0]  s0_addr,
   input  logic [DATA_WIDTH-1:0] s0_data,
   output logic                  s0_ready,
   input  logic                  s1_valid,
   input  logic [REG_WIDTH-1:0]  s1_addr,
   input  logic [DATA_WIDTH-1:0] s1_data,
   output logic                  s1_ready,
   output logic                  rf_wen,
   output logic [REG_WIDTH-1:0]  rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [REG_WIDTH-1:0]  chk_addr1,
   input  logic [REG_WIDTH-1:0]  chk_addr2,
   output logic                  chk_busy1,
   output logic                  chk_busy2,
   input  logic                  flush,
   output logic                  idle,
   output logic                  err
);

   localparam int NREG = 1 << REG_WIDTH;
   localparam logic [REG_WIDTH-1:0] ZERO_ADDR = {REG_WIDTH{1'b0}};

   logic [NREG-1:0]       busy_q, busy_d;
   logic                  ptr_q, ptr_d;        // 0 favours s0 on contention
   logic                  rf_wen_q, rf_wen_d;
   logic [REG_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  err_q, err_d;

   logic                  grant0_s, grant1_s, wb_fire_s, alloc_fire_s;
   logic [REG_WIDTH-1:0]  wb_addr_s;
   logic [DATA_WIDTH-1:0] wb_data_s;

   // Arbitration: a lone valid source always wins, contention follows ptr_q.
   always_comb begin
      grant0_s  = s0_valid & (~s1_valid | ~ptr_q);
      grant1_s  = s1_valid & (~s0_valid |  ptr_q);
      wb_fire_s = grant0_s | grant1_s;
      if (grant1_s) begin
         wb_addr_s = s1_addr;
         wb_data_s = s1_data;
      end else begin
         wb_addr_s = s0_addr;
         wb_data_s = s0_data;
      end
   end

   // Reservation acceptance; a release in this cycle is not bypassed.
   always_comb begin
      alloc_ready  = ~flush & ((alloc_addr == ZERO_ADDR) | ~busy_q[alloc_addr]);
      alloc_fire_s = alloc_valid & alloc_ready & (alloc_addr != ZERO_ADDR);
   end

   // Next-state computation for scoreboard, pointer, output register and err.
   always_comb begin
      busy_d     = busy_q;
      ptr_d      = ptr_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_wen_d   = 1'b0;
      err_d      = err_q;
      if (wb_fire_s) begin
         busy_d[wb_addr_s] = 1'b0;
         ptr_d             = grant0_s;   // point at the source that lost
         rf_wen_d          = (wb_addr_s != ZERO_ADDR);
         rf_waddr_d        = wb_addr_s;
         rf_wdata_d        = wb_data_s;
         // An unreserved target is an error, except while flushing, where the
         // reservation may legitimately be in the middle of being discarded.
         if (~flush & (wb_addr_s != ZERO_ADDR) & ~busy_q[wb_addr_s]) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         ptr_d = ptr_q;
      end
      // Allocation after release so a same-cycle re-reservation survives.
      if (alloc_fire_s) begin
         busy_d[alloc_addr] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (flush) begin
         busy_d = {NREG{1'b0}};
      end else begin
         busy_d = busy_d;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset also discards a write pending in the output stage.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q     <= {NREG{1'b0}};
         ptr_q      <= 1'b0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= {REG_WIDTH{1'b0}};
         rf_wdata_q <= {DATA_WIDTH{1'b0}};
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         err_q      <= err_d;
      end
   end

   // Output drive and hazard queries; the pending regfile write counts as busy.
   always_comb begin
      s0_ready  = grant0_s;
      s1_ready  = grant1_s;
      rf_wen    = rf_wen_q;
      rf_waddr  = rf_waddr_q;
      rf_wdata  = rf_wdata_q;
      err       = err_q;
      idle      = (busy_q == {NREG{1'b0}}) & ~rf_wen_q;
      chk_busy1 = (chk_addr1 != ZERO_ADDR) &
                  (busy_q[chk_addr1] | (rf_wen_q & (rf_waddr_q == chk_addr1)));
      chk_busy2 = (chk_addr2 != ZERO_ADDR) &
                  (busy_q[chk_addr2] | (rf_wen_q & (rf_waddr_q == chk_addr2)));
   end

endmodule

// File: tb/tb_ysyx_23060208_wb_sched.sv
// tb_ysyx_23060208_wb_sched
// Directed scenarios followed by randomized traffic, every cycle compared
// against a scoreboard model built from the behavioural rules of the block.
module tb_ysyx_23060208_wb_sched;

   logic        clock = 1'b0;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_addr;
   logic        alloc_ready;
   logic        s0_valid, s1_valid;
   logic [4:0]  s0_addr, s1_addr;
   logic [31:0] s0_data, s1_data;
   logic        s0_ready, s1_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  chk_addr1, chk_addr2;
   logic        chk_busy1, chk_busy2;
   logic        flush, idle, err;

   always #5 clock = ~clock;

   ysyx_23060208_wb_sched #(.REG_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
      .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
      .flush(flush), .idle(idle), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: set of reserved registers, who wins the next tie,
   // the write waiting in the output stage, and the sticky error.
   bit [31:0] m_busy;
   bit        m_favour_s1;
   bit        m_wen;
   bit [4:0]  m_waddr;
   bit [31:0] m_wdata;
   bit        m_err;

   task automatic model_reset();
      m_busy = 32'd0; m_favour_s1 = 1'b0; m_wen = 1'b0;
      m_waddr = 5'd0; m_wdata = 32'd0; m_err = 1'b0;
   endtask

   task automatic clear_inputs();
      alloc_valid = 1'b0; alloc_addr = 5'd0;
      s0_valid = 1'b0; s0_addr = 5'd0; s0_data = 32'd0;
      s1_valid = 1'b0; s1_addr = 5'd0; s1_data = 32'd0;
      chk_addr1 = 5'd0; chk_addr2 = 5'd0; flush = 1'b0;
   endtask

   // One clock cycle: drive, compare all outputs against the model, advance.
   task automatic cyc(input bit av, input bit [4:0] aa,
                      input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                      input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                      input bit fl, input bit [4:0] c1, input bit [4:0] c2);
      int        g;
      bit        e_ar;
      bit [4:0]  wa;
      bit [31:0] wd;
      bit [31:0] nb;
      @(negedge clock);
      alloc_valid = av; alloc_addr = aa;
      s0_valid = v0; s0_addr = a0; s0_data = d0;
      s1_valid = v1; s1_addr = a1; s1_data = d1;
      flush = fl; chk_addr1 = c1; chk_addr2 = c2;
      #1;
      e_ar = !fl && (aa == 5'd0 || !m_busy[aa]);
      if (v0 && v1) g = m_favour_s1 ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      else          g = -1;
      check_val("alloc_ready", 64'(alloc_ready), 64'(e_ar));
      check_val("s0_ready", 64'(s0_ready), 64'(g == 0));
      check_val("s1_ready", 64'(s1_ready), 64'(g == 1));
      check_val("chk_busy1", 64'(chk_busy1),
                64'(c1 != 5'd0 && (m_busy[c1] || (m_wen && m_waddr == c1))));
      check_val("chk_busy2", 64'(chk_busy2),
                64'(c2 != 5'd0 && (m_busy[c2] || (m_wen && m_waddr == c2))));
      check_val("idle", 64'(idle), 64'(m_busy == 32'd0 && !m_wen));
      check_val("rf_wen", 64'(rf_wen), 64'(m_wen));
      check_val("err", 64'(err), 64'(m_err));
      if (m_wen) begin
         check_val("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
         check_val("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      end
      nb = m_busy;
      wa = (g == 1) ? a1 : a0;
      wd = (g == 1) ? d1 : d0;
      if (g >= 0) begin
         if (wa != 5'd0 && !m_busy[wa] && !fl) m_err = 1'b1;
         nb[wa] = 1'b0;
         m_favour_s1 = (g == 0);
      end
      if (av && e_ar && aa != 5'd0) nb[aa] = 1'b1;
      if (fl) nb = 32'd0;
      @(posedge clock);
      m_busy = nb;
      m_wen  = (g >= 0) && (wa != 5'd0);
      if (m_wen) begin
         m_waddr = wa;
         m_wdata = wd;
      end
   endtask

   task automatic idle_cyc(input bit [4:0] c1);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, c1, 5'd0);
   endtask

   // Reset pulse away from the clock edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clock);
      clear_inputs();
      #2 reset = 1'b0;
      #1;
      check_val("rst_rf_wen", 64'(rf_wen), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_idle", 64'(idle), 64'd1);
      check_val("rst_waddr", 64'(rf_waddr), 64'd0);
      check_val("rst_wdata", 64'(rf_wdata), 64'd0);
      check_val("rst_alloc_ready", 64'(alloc_ready), 64'd1);
      check_val("rst_chk_busy1", 64'(chk_busy1), 64'd0);
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      reset = 1'b0;
      #12;
      do_reset();

      // Reserve x5, write it back from s0, observe the output register and idle.
      cyc(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
      cyc(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
      #1;
      check_val("x5_wen", 64'(rf_wen), 64'd1);
      check_val("x5_waddr", 64'(rf_waddr), 64'd5);
      check_val("x5_wdata", 64'(rf_wdata), 64'hDEADBEEF);
      check_val("x5_chk_bypass", 64'(chk_busy1), 64'd1);
      idle_cyc(5'd5);
      #1;
      check_val("x5_idle", 64'(idle), 64'd1);

      // Contention for four cycles from a fresh pointer.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 5'd0, 1'b1, 5'd10, 32'(i), 1'b1, 5'd11, 32'(100 + i), 1'b0, 5'd0, 5'd0);
         #1;
         check_val("rr_addr", 64'(rf_waddr), (i % 2 == 0) ? 64'd10 : 64'd11);
      end

      // Busy x7 blocks re-reservation until its writeback is accepted.
      do_reset();
      cyc(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
      cyc(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
      cyc(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 5'd0);
      cyc(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);

      // Unreserved write sets sticky err; x0 write handshakes without rf_wen.
      do_reset();
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd0);
      cyc(1'b0, 5'd0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      #1;
      check_val("x0_no_wen", 64'(rf_wen), 64'd0);
      check_val("err_sticky", 64'(err), 64'd1);
      idle_cyc(5'd0);

      // Flush with a same-cycle allocation and writeback.
      do_reset();
      cyc(1'b1, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);
      cyc(1'b1, 5'd4, 1'b1, 5'd1, 32'h1111, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2);
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd2);
      idle_cyc(5'd4);

      // Reset while a write sits in the output register.
      do_reset();
      cyc(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0);
      do_reset();
      idle_cyc(5'd9);
      idle_cyc(5'd9);

      // Randomized traffic on a small register window to force collisions.
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom % 2) == 0, 5'($urandom % 8),
             ($urandom % 3) == 0, 5'($urandom % 8), $urandom,
             ($urandom % 3) == 0, 5'($urandom % 8), $urandom,
             ($urandom % 16) == 0, 5'($urandom % 8), 5'($urandom % 32));
         if (i == 400) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060208_wb_sched.md
YSYX_23060208_WB_SCHED -- requirements
Module: ysyx_23060208_wb_sched

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 5, regfile address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, regfile data width.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alloc_valid input 1, alloc_addr input REG_WIDTH, alloc_ready output 1  destination-register reservation from issue.
REQ-006 SHALL have ports s0_valid input 1, s0_addr input REG_WIDTH, s0_data input DATA_WIDTH, s0_ready output 1  writeback source 0 (EXU).
REQ-007 SHALL have ports s1_valid input 1, s1_addr input REG_WIDTH, s1_data input DATA_WIDTH, s1_ready output 1  writeback source 1 (LSU).
REQ-008 SHALL have ports rf_wen output 1, rf_waddr output REG_WIDTH, rf_wdata output DATA_WIDTH  regfile write port drive.
REQ-009 SHALL have ports chk_addr1, chk_addr2 input REG_WIDTH; chk_busy1, chk_busy2 output 1  hazard query for the two read ports.
REQ-010 SHALL have port flush input 1  discard all reservations.
REQ-011 SHALL have ports idle output 1 and err output 1  status.

Function
REQ-012 SHALL hold a busy bit per register, 2**REG_WIDTH entries; entry 0 SHALL always read 0.
REQ-013 SHALL drive alloc_ready = !flush & (alloc_addr==0 | !busy[alloc_addr]), combinational, no same-cycle bypass of a release.
REQ-014 SHALL set busy[alloc_addr] at the edge where alloc_valid & alloc_ready & alloc_addr!=0.
REQ-015 SHALL grant at most one writeback source per cycle; sN_ready is combinational and SHALL equal its grant.
REQ-016 SHALL grant the only valid source when one is valid; when both are valid, grant per a 1-bit round-robin pointer (0 favours s0).
REQ-017 SHALL set the pointer to the non-granted source after every grant; no grant leaves it unchanged.
REQ-018 SHALL register the granted address and data, giving rf_wen/rf_waddr/rf_wdata exactly one cycle after the handshake; no grant gives rf_wen=0 next cycle.
REQ-019 SHALL suppress rf_wen for an accepted writeback with address 0; the handshake still completes.
REQ-020 SHALL clear busy[addr] at the handshake edge of an accepted writeback.
REQ-021 SHALL set err (sticky) when an accepted writeback targets a nonzero address whose busy bit is 0; data SHALL still be written.
REQ-022 SHALL drive chk_busyN = (chk_addrN!=0) & (busy[chk_addrN] | (rf_wen & rf_waddr==chk_addrN)), combinational.
REQ-023 SHALL on flush clear all busy bits at the next edge; flush SHALL win over a same-cycle allocation; a same-cycle writeback SHALL still be accepted and written, without setting err.
REQ-024 SHALL never stall writeback sources for reasons other than arbitration loss.
REQ-025 SHALL drive idle = no busy bit set & rf_wen==0.
REQ-026 SHALL keep s0_ready=s1_ready=0 when neither source is valid.

Reset
REQ-027 SHALL while reset=0 force all busy bits 0, pointer 0, rf_wen 0, rf_waddr 0, rf_wdata 0, err 0, asynchronously.
REQ-028 SHALL after reset drive idle=1, alloc_ready=1 (flush low), chk_busy1=chk_busy2=0.
REQ-029 SHALL drop any writeback pending in the output register when reset asserts mid-operation; no rf_wen after release.

Verification
REQ-030 SHALL cover: alloc x5, then s0 writes x5=0xDEADBEEF -> chk_busy1(x5)=1 until handshake+1; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle after; then idle=1.
REQ-031 SHALL cover: s0 and s1 valid together for 4 cycles, pointer 0 -> grants s0,s1,s0,s1; exactly one ready per cycle.
REQ-032 SHALL cover: x7 busy, alloc x7 -> alloc_ready=0; writeback x7 accepted -> alloc_ready=1 the next cycle.
REQ-033 SHALL cover: s1 writes x3 with x3 not busy -> err=1 and stays 1; s0 writes x0 -> s0_ready=1, rf_wen=0.
REQ-034 SHALL cover: x1,x2 busy, flush with alloc x4 and s0 writeback x1 same cycle -> all busy 0 next cycle, x4 not busy, x1 written, err=0.
REQ-035 SHALL cover: reset low while rf_wen pending -> rf_wen=0 immediately, idle=1 after release.
